// File: rtl/bn_layer_stream_reader.sv
// ---------------------------------------------------------------------------
// bn_layer_stream_reader
//
// Purpose:
//   Drains a packed batch-normalization feature-map bus (layer_in) one
//   DATA_WIDTH element per handshake. Each element leaves on a valid/ready
//   stream tagged with its filter, row and column index. Order is filter
//   outermost, then row, then column:
//     e = (f*DEPTH*INPUT + r)*INPUT + c
//     out_data = layer_in[e*DATA_WIDTH +: DATA_WIDTH]
//
// Optional feature (compile-time macro BN_STREAM_RELU_EN):
//   When defined, an element whose sign bit is set (negatives, -0.0,
//   negative NaN) is emitted as all zeros. Tags, handshake and timing are
//   unchanged. When undefined, elements pass bit-exact.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset, returns to IDLE
//   start       in   begin a drain; sampled only in IDLE
//   layer_in    in   ELEMS*DATA_WIDTH packed layer, held stable until done
//   out_data    out  current element (registered)
//   out_valid   out  out_data / tags / out_last are valid
//   out_ready   in   consumer accepts the element this cycle
//   out_filter  out  filter index f
//   out_row     out  row index r
//   out_col     out  column index c
//   out_last    out  high with the final element (index ELEMS-1)
//   busy        out  high while streaming
//   done        out  one-cycle pulse after the last handshake
//   dbg_state   out  current FSM state encoding (0 IDLE, 1 STREAM, 2 DONE)
//
// Handshake: an element transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, and data,
// tags and out_last stay constant, until that transfer happens.
// ---------------------------------------------------------------------------
module bn_layer_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FILTERS    = 64,
  parameter int DEPTH      = 1,
  parameter int INPUT      = 30,
  localparam int ROWS  = DEPTH * INPUT,
  localparam int ELEMS = FILTERS * ROWS * INPUT,
  localparam int FW    = (FILTERS > 1) ? $clog2(FILTERS) : 1,
  localparam int RW    = (ROWS > 1)    ? $clog2(ROWS)    : 1,
  localparam int CW    = (INPUT > 1)   ? $clog2(INPUT)   : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ELEMS*DATA_WIDTH-1:0] layer_in,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FW-1:0]               out_filter,
  output logic [RW-1:0]               out_row,
  output logic [CW-1:0]               out_col,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  // Flat element index, kept alongside the f/r/c tags so the data mux
  // needs no multiply of the tag counters.
  localparam int IW = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state;

  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_nxt;
  logic [FW-1:0]         f_nxt;
  logic [RW-1:0]         r_nxt;
  logic [CW-1:0]         c_nxt;
  logic [IW-1:0]         sel_idx;
  logic [DATA_WIDTH-1:0] elem_raw;
  logic [DATA_WIDTH-1:0] elem_out;
  logic                  handshake;
  logic                  last_nxt;

  assign handshake = out_valid & out_ready;
  assign dbg_state = state;

  // Successor of the current tag triple: column runs fastest, row wraps
  // into filter.
  always_comb begin
    c_nxt   = out_col + 1'b1;
    r_nxt   = out_row;
    f_nxt   = out_filter;
    if (out_col == CW'(INPUT - 1)) begin
      c_nxt = '0;
      r_nxt = out_row + 1'b1;
      if (out_row == RW'(ROWS - 1)) begin
        r_nxt = '0;
        f_nxt = out_filter + 1'b1;
      end
    end
    idx_nxt  = idx_q + 1'b1;
    last_nxt = (idx_nxt == IW'(ELEMS - 1));
  end

  // The mux is steered by the index the stream will show next, so the
  // registered data lands in the same cycle as its tags. In IDLE the next
  // element is always element 0. On the final element there is no
  // successor; the index is parked at 0 so the select never runs past the
  // end of the bus (the value is not loaded in that case anyway).
  always_comb begin
    sel_idx = '0;
    if (state == S_STREAM && !out_last) begin
      sel_idx = idx_nxt;
    end
    elem_raw = layer_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef BN_STREAM_RELU_EN
  // Sign-bit test rather than a float compare: clamps -0.0 and negative NaN
  // too, which is what a bit-level ReLU on IEEE-754 should do.
  assign elem_out = elem_raw[DATA_WIDTH-1] ? '0 : elem_raw;
`else
  assign elem_out = elem_raw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idx_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_filter <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= S_STREAM;
            idx_q      <= '0;
            out_filter <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_data   <= elem_out;
            out_last   <= (ELEMS == 1);
            out_valid  <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_STREAM: begin
          if (handshake) begin
            if (out_last) begin
              // Tags and data are left as they were; only valid drops.
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx_q      <= idx_nxt;
              out_filter <= f_nxt;
              out_row    <= r_nxt;
              out_col    <= c_nxt;
              out_data   <= elem_out;
              out_last   <= last_nxt;
            end
          end
        end

        S_DONE: begin
          // Unconditional one-cycle visit; a start seen here is dropped.
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bn_layer_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bn_layer_stream_reader
//
// Self-checking bench for bn_layer_stream_reader with FILTERS=2, DEPTH=1,
// INPUT=3 (18 elements). The driver pushes the full expected beat list into
// exp_q when it issues start; a monitor on the falling edge pops and
// compares on every accepted beat, checks stability under backpressure,
// and checks the done pulse position and width.
// ---------------------------------------------------------------------------
module tb_bn_layer_stream_reader;

  localparam int DW    = 32;
  localparam int FIL   = 2;
  localparam int DEP   = 1;
  localparam int INP   = 3;
  localparam int ROWS  = DEP * INP;
  localparam int ELEMS = FIL * ROWS * INP;
  localparam int FW    = 1;
  localparam int RW    = 2;
  localparam int CW    = 2;
  localparam int EW    = 1 + FW + RW + CW + DW;

`ifdef BN_STREAM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                  start = 1'b0;
  logic [ELEMS*DW-1:0]   layer_in = '0;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [FW-1:0]         out_filter;
  logic [RW-1:0]         out_row;
  logic [CW-1:0]         out_col;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [1:0]            dbg_state;

  bn_layer_stream_reader #(
    .DATA_WIDTH(DW), .FILTERS(FIL), .DEPTH(DEP), .INPUT(INP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .layer_in(layer_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_filter(out_filter), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] model [ELEMS];
  logic [EW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  // IEEE-754 single encodings of 4*r for r = 0, 1, 2.
  function automatic logic [DW-1:0] four_r_bits(input int r);
    case (r)
      0:       return 32'h0000_0000;
      1:       return 32'h4080_0000;
      default: return 32'h4100_0000;
    endcase
  endfunction

  function automatic logic [EW-1:0] exp_beat(input int e);
    int f, r, c;
    logic [DW-1:0] v;
    f = e / (ROWS * INP);
    r = (e / INP) % ROWS;
    c = e % INP;
    v = model[e];
    if (RELU && v[DW-1]) v = '0;
    return {(e == ELEMS - 1), FW'(f), RW'(r), CW'(c), v};
  endfunction

  task automatic fill_4r();
    for (int e = 0; e < ELEMS; e++) model[e] = four_r_bits((e / INP) % ROWS);
  endtask

  task automatic fill_random();
    for (int e = 0; e < ELEMS; e++) model[e] = $urandom();
  endtask

  task automatic load_layer();
    for (int e = 0; e < ELEMS; e++) layer_in[e*DW +: DW] = model[e];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] cur_beat;
  assign cur_beat = {out_last, out_filter, out_row, out_col, out_data};

  int  hs_cnt = 0;
  int  stall_cnt = 0;
  int  start_edge = 0;
  int  done_edge = 0;
  bit  done_seen = 1'b0;

  initial begin
    logic [EW-1:0] held;
    logic [EW-1:0] expv;
    bit hold_pending;
    bit prev_done;
    hold_pending = 1'b0;
    prev_done = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_pending = 1'b0;
        prev_done = 1'b0;
        continue;
      end
      check("valid_vs_busy", out_valid, busy);
      if (hold_pending) begin
        check("stall_hold", cur_beat, held);
        hold_pending = 1'b0;
      end
      if (prev_done) check("done_width", done, 0);
      prev_done = done;
      if (out_valid) begin
        if (!out_ready) begin
          held = cur_beat;
          hold_pending = 1'b1;
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", cur_beat, cyc);
        end else begin
          expv = exp_q.pop_front();
          check("beat", cur_beat, expv);
          hs_cnt++;
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_edge = cyc;
        check("done_timing", cyc, start_edge + ELEMS + stall_cnt);
        check("done_queue_empty", exp_q.size(), 0);
        check("done_valid_low", out_valid, 0);
      end
    end
  end

  // ---------------- driver ----------------
  // mode 0: ready always high; 1: 1,0,1,0... from the first valid cycle;
  // 2: random ready. repulse re-asserts start at beats 5 and 18 and in the
  // done cycle. rst_at >= 0 pulls reset mid-stream once that many beats
  // have been accepted. dur returns done cycle minus start cycle (-1 if
  // the stream did not complete).
  task automatic run_stream(input int mode, input bit repulse, input int rst_at, output int dur);
    int guard;
    int phase;
    hs_cnt = 0;
    stall_cnt = 0;
    done_seen = 1'b0;
    dur = -1;
    for (int e = 0; e < ELEMS; e++) exp_q.push_back(exp_beat(e));
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start_edge = cyc;
    start = 1'b0;
    phase = 0;
    guard = 0;
    while (!done_seen && guard < 400) begin
      if (rst_at >= 0 && hs_cnt == rst_at) begin
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_tags", {out_filter, out_row, out_col}, 0);
        exp_q.delete();
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #4;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (phase % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = repulse && (hs_cnt == 4 || hs_cnt == 17 || done === 1'b1);
      phase++;
      guard++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", hs_cnt, ELEMS);
      exp_q.delete();
    end else begin
      dur = done_edge - start_edge;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_last", out_last, 0);
    check("reset_data", out_data, 0);
    check("reset_tags", {out_filter, out_row, out_col}, 0);
    @(posedge clk); #4;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", out_valid, 0);

    // 1: full-rate stream of the 4*r pattern
    fill_4r();
    load_layer();
    run_stream(0, 1'b0, -1, d);
    check("s1_duration", d, ELEMS);

    // 2: alternating backpressure, done 17 cycles later
    run_stream(1, 1'b0, -1, d);
    check("s2_duration", d, ELEMS + 17);

    // 3: start re-pulsed mid-stream, on the last beat and in DONE
    run_stream(0, 1'b1, -1, d);
    check("s3_duration", d, ELEMS);

    // 4: asynchronous reset at beat 7, then a clean restart from (0,0,0)
    run_stream(0, 1'b0, 6, d);
    check("s4_aborted", d, -1);
    run_stream(0, 1'b0, -1, d);
    check("s4_restart_duration", d, ELEMS);

    // 5: a negative element at index 4
    model[4] = 32'hC080_0000;
    load_layer();
    run_stream(0, 1'b0, -1, d);
    check("s5_duration", d, ELEMS);

    // random contents with random and alternating backpressure
    for (int k = 0; k < 4; k++) begin
      fill_random();
      load_layer();
      run_stream((k == 3) ? 1 : 2, k[0], -1, d);
      check("rand_completed", (d >= ELEMS), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bn_layer_stream_reader.md
# bn_layer_stream_reader

Drains a packed feature-map bus, as produced by `batch_normalization_layer.output_layer`, one `DATA_WIDTH` element per handshake. Output is a valid/ready stream tagged with filter, row and column indices. It sits between the batch-normalization stage and any downstream consumer that cannot take the full-width layer bus in one cycle, such as a pooling unit, a log/DMA writer or the next stage's loader. It is the read-side counterpart of the element-wise packing used to fill `input_layer`.

## Interface
- `DATA_WIDTH`, 32: bits per element (IEEE-754 single).
- `FILTERS`, 64: number of filter planes.
- `DEPTH`, 1: depth multiplier on rows.
- `INPUT`, 30: columns per row; rows per plane = `DEPTH*INPUT`.
- Derived, local: `ELEMS = FILTERS*DEPTH*INPUT*INPUT`; `FW = clog2(FILTERS)`, `RW = clog2(DEPTH*INPUT)`, `CW = clog2(INPUT)`, each at least 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin draining `layer_in`. Sampled only in IDLE.
- `layer_in`, in, `ELEMS*DATA_WIDTH`: packed layer. Must be held stable from the `start` cycle until `done`.
- `out_data`, out, `DATA_WIDTH`: current element.
- `out_valid`, out, 1: `out_data` and the tag outputs are valid.
- `out_ready`, in, 1: consumer accepts the element when high together with `out_valid`.
- `out_filter`, out, `FW`: filter index f.
- `out_row`, out, `RW`: row index r.
- `out_col`, out, `CW`: column index c.
- `out_last`, out, 1: high with the final element (index `ELEMS-1`).
- `busy`, out, 1: high in STREAM.
- `done`, out, 1: one-cycle pulse after the last handshake.

## Operation
- Element order: f outer, r middle, c inner.
- Element index e = (f*DEPTH*INPUT + r)*INPUT + c. `out_data` = `layer_in[e*DATA_WIDTH +: DATA_WIDTH]`.
- FSM states are IDLE, STREAM and DONE.
- IDLE → STREAM on `start`. The f/r/c counters clear to 0 and `out_valid` is set.
- In STREAM, a handshake (`out_valid & out_ready`) advances the counters:
  - c increments.
  - When c = `INPUT-1`, c wraps to 0 and r increments.
  - When r = `DEPTH*INPUT-1`, r wraps to 0 and f increments.
- A handshake with `out_last`=1 moves STREAM → DONE and clears `out_valid`.
- DONE → IDLE unconditionally after one cycle. `done`=1 only while in DONE.
- Without a handshake, `out_data`, the tags and `out_last` hold. `out_valid` never drops before the handshake.
- `start` in STREAM or DONE is ignored. There is no queuing.
- `start` asserted in the cycle DONE → IDLE is also ignored. A new `start` is needed once in IDLE.
- `out_data` is a registered mux of `layer_in` indexed by the next counter value, so data always aligns with the tags.
- Reset (`reset_n`=0, at any time, including mid-stream) returns the block to IDLE immediately:
  - `out_valid`, `busy`, `done` and `out_last` = 0.
  - `out_data`, `out_filter`, `out_row` and `out_col` = 0.
  - The partial stream is discarded. Nothing resumes after reset.

## Timing
- `start` high at edge N: `out_valid`=1 with element 0 after edge N, so the first element is visible in cycle N+1.
- With `out_ready` held high: one element per cycle. The last handshake is at cycle N+`ELEMS`, `done` pulses in cycle N+`ELEMS`+1, and IDLE is entered in cycle N+`ELEMS`+2.
- Earliest next `start` is sampled at the end of cycle N+`ELEMS`+2.
- Backpressure adds exactly one cycle per cycle that `out_ready` is low while `out_valid`=1.
- `layer_in` has no combinational path to the outputs. All outputs are registered.

## Configuration
- `BN_STREAM_RELU_EN` defined:
  - `out_data` is replaced by 0 when the element's sign bit (`DATA_WIDTH-1`) is 1. This covers -0.0 and negative NaN.
  - The tags, the handshake and the timing are unchanged.
- `BN_STREAM_RELU_EN` undefined: `out_data` passes the element bit-exact.

## Test plan
Bench parameters: `FILTERS`=2, `DEPTH`=1, `INPUT`=3, giving `ELEMS`=18. Element e is loaded as the float value 4*r.

1. `out_ready`=1 and one `start` pulse → 18 consecutive beats.
   - Tags: (0,0,0), (0,0,1), (0,0,2), (0,1,0) … (1,2,2).
   - Data: 0.0, 0.0, 0.0, 4.0 … 8.0.
   - `out_last` only on beat 18; `done` one cycle later.
2. Backpressure: `out_ready` toggles 1,0,1,0… → the beat sequence is identical to scenario 1 and `done` arrives 17 cycles later than in scenario 1. No beat is duplicated or skipped, and data and tags are stable while `out_ready`=0.
3. `start` re-pulsed at beats 5 and 18 and in the DONE cycle → no restart; the sequence and `done` timing match scenario 1.
4. `reset_n` pulled low mid-stream at beat 7, asynchronously between edges:
   - `out_valid`, `busy`, `done` and `out_last` go to 0 immediately.
   - After release and a new `start`, the stream begins again at (0,0,0).
5. Element 4 set to 0xC0800000 (-4.0):
   - With `BN_STREAM_RELU_EN`, beat 5 data is 0x00000000.
   - Without it, beat 5 data is 0xC0800000.
   - All other beats are unchanged.
